display_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the shared seven-segment decoder on the digital clock board. It holds a frame of BCD digits, selects one digit position at a time, and presents that digit's code to the single decoder instance. A blanking gap between digits suppresses ghosting. New frames are committed only at frame boundaries, so the display never tears, and it supports per-digit blinking for time-setting mode.

---
 rtl/display_scan_ctrl_if.sv | 23 ++
 rtl/display_scan_ctrl.sv | 105 ++++++++++
 tb/tb_display_scan_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/display_scan_ctrl_if.sv
// Scan-controller bus: frame/blink controls in, decoder code and digit enables out.
// No backpressure; the controls are level/strobe inputs and the outputs are registered.
interface display_scan_ctrl_if #(
  parameter int NUM_DIGITS = 6
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    load;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    blink_phase;
  logic [3:0]              num_out;
  logic [NUM_DIGITS-1:0]   dig_sel_n;
  logic                    frame_done;

  modport master (
    output digits_in, load, blink_mask, blink_phase,
    input  num_out, dig_sel_n, frame_done
  );

  modport slave (
    input  digits_in, load, blink_mask, blink_phase,
    output num_out, dig_sel_n, frame_done
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Multiplexed seven-segment scan with blank gaps, frame-boundary commits and blinking; 1-cycle registered outputs.
// No backpressure: load is always accepted and the last load before a frame wrap wins.
module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                clk,
  input  logic                rst_n,
  display_scan_ctrl_if.slave  bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [0:0]              state;
  logic                    win_end;
  logic                    frame_end;
  logic [3:0]              digit;
  logic [NUM_DIGITS-1:0]   sel_dec;

  logic [4*NUM_DIGITS-1:0] active;
  logic [4*NUM_DIGITS-1:0] pending;
  logic                    pend_valid;
  logic [NUM_DIGITS-1:0]   mask_q;
  logic                    phase_q;

  logic [3:0]              num_q;
  logic [NUM_DIGITS-1:0]   sel_q;
  logic                    done_q;

  // cnt/idx name the scan position that the next edge will present on the outputs.
  always_comb begin
    state     = (cnt < CNT_BLANK) ? ST_BLANK : ST_SHOW;
    win_end   = (cnt == CNT_LAST);
    frame_end = win_end && (idx == IDX_LAST);
    digit     = active[{idx, 2'b00} +: 4];
    sel_dec   = ~(NUM_DIGITS'(1) << idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (win_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // done_q high means the current cycle is the last of the frame, so this edge is the frame wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active     <= '1;
      pending    <= '1;
      pend_valid <= 1'b0;
    end else if (done_q) begin
      if (bus.load) begin
        active     <= bus.digits_in;
        pend_valid <= 1'b0;
      end else if (pend_valid) begin
        active     <= pending;
        pend_valid <= 1'b0;
      end
    end else if (bus.load) begin
      pending    <= bus.digits_in;
      pend_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q  <= '0;
      phase_q <= 1'b0;
      num_q   <= 4'hF;
      sel_q   <= '1;
      done_q  <= 1'b0;
    end else begin
      mask_q  <= bus.blink_mask;
      phase_q <= bus.blink_phase;
      done_q  <= frame_end;
      if (state == ST_BLANK) begin
        sel_q <= '1;
        num_q <= 4'hF;
      end else begin
        sel_q <= sel_dec;
        num_q <= (mask_q[idx] && phase_q) ? 4'hF : digit;
      end
    end
  end

  assign bus.num_out    = num_q;
  assign bus.dig_sel_n  = sel_q;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed plus randomized bench for display_scan_ctrl against a frame-level reference model.
module tb_display_scan_ctrl;
  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BL = 2;
  localparam int FR = ND * SD;

  logic clk;
  logic rst_n;

  display_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  display_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          vectors;
  int          miscompares;
  int          n_edges;
  int          cur_p;
  logic [15:0] m_active;
  logic [15:0] m_pending;
  bit          m_pv;
  logic [3:0]  prev_mask;
  logic        prev_phase;
  logic [3:0]  g_mask;
  logic        g_phase;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s got %h exp %h (edge %0d pos %0d)", tag, got, exp, n_edges, cur_p);
    end
  endtask

  task automatic model_reset();
    n_edges    = 0;
    cur_p      = 0;
    m_active   = 16'hFFFF;
    m_pending  = 16'hFFFF;
    m_pv       = 1'b0;
    prev_mask  = 4'h0;
    prev_phase = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sel"}, {4'h0, bus.dig_sel_n}, 8'h0F);
    chk({tag, "_num"}, {4'h0, bus.num_out}, 8'h0F);
    chk({tag, "_fd"}, {7'h0, bus.frame_done}, 8'h00);
  endtask

  // One clock: apply inputs, take the edge, then compare with the frame-level model.
  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] mk, input logic ph);
    int         c;
    int         i;
    bit         wrap;
    logic [3:0] e_sel;
    logic [3:0] e_num;
    logic       e_fd;
    bus.load        = ld;
    bus.digits_in   = d;
    bus.blink_mask  = mk;
    bus.blink_phase = ph;
    @(posedge clk);
    #1;
    n_edges++;
    cur_p = (n_edges - 1) % FR;
    wrap  = (n_edges >= 2) && (((n_edges - 2) % FR) == FR - 1);
    if (wrap) begin
      if (ld) begin
        m_active = d;
        m_pv     = 1'b0;
      end else if (m_pv) begin
        m_active = m_pending;
        m_pv     = 1'b0;
      end
    end else if (ld) begin
      m_pending = d;
      m_pv      = 1'b1;
    end
    c = cur_p % SD;
    i = cur_p / SD;
    if (c < BL) begin
      e_sel = 4'hF;
      e_num = 4'hF;
    end else begin
      e_sel    = 4'hF;
      e_sel[i] = 1'b0;
      e_num    = (prev_mask[i] && prev_phase) ? 4'hF : m_active[4*i +: 4];
    end
    e_fd       = (cur_p == FR - 1);
    prev_mask  = mk;
    prev_phase = ph;
    chk("dig_sel_n", {4'h0, bus.dig_sel_n}, {4'h0, e_sel});
    chk("num_out", {4'h0, bus.num_out}, {4'h0, e_num});
    chk("frame_done", {7'h0, bus.frame_done}, {7'h0, e_fd});
    chk("sel_onehot", {7'h0, ($countones(~bus.dig_sel_n) <= 1)}, 8'h01);
  endtask

  task automatic idle_step();
    step(1'b0, 16'($urandom), g_mask, g_phase);
  endtask

  task automatic run_to(input int target);
    do idle_step(); while (cur_p != target);
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    g_mask          = 4'h0;
    g_phase         = 1'b0;
    rst_n           = 1'b0;
    bus.load        = 1'b0;
    bus.digits_in   = 16'h0;
    bus.blink_mask  = 4'h0;
    bus.blink_phase = 1'b0;
    model_reset();

    // Reset and idle: outputs dark while held, then two blank-padded frames of F.
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_reset_outputs("in_reset");
    end
    rst_n = 1'b1;
    repeat (2 * FR) idle_step();

    // Mid-frame load: current frame stays F, next frame shows 4,3,2,1.
    run_to(10);
    step(1'b1, 16'h1234, g_mask, g_phase);
    run_to(FR - 1);
    run_to(FR - 1);

    // Load in the frame_done cycle commits straight to the next frame.
    step(1'b1, 16'h5678, g_mask, g_phase);
    run_to(FR - 1);

    // Two loads in one frame: only the later value appears.
    run_to(5);
    step(1'b1, 16'h1111, g_mask, g_phase);
    run_to(12);
    step(1'b1, 16'h2222, g_mask, g_phase);
    run_to(FR - 1);
    run_to(FR - 1);

    // Blink: digits 0-1 dark while phase is high, all shown when low.
    step(1'b1, 16'h1234, 4'b0011, 1'b1);
    g_mask  = 4'b0011;
    g_phase = 1'b1;
    run_to(FR - 1);
    g_phase = 1'b0;
    run_to(FR - 1);

    // Randomized loads (including codes 10-15), blink masks and phases.
    for (int k = 0; k < 10 * FR; k++) begin
      if ($urandom_range(0, 15) == 0) g_mask = 4'($urandom);
      if ($urandom_range(0, 9) == 0) g_phase = ~g_phase;
      step(($urandom_range(0, 19) == 0), 16'($urandom), g_mask, g_phase);
    end

    // Asynchronous reset in the SHOW phase of digit 2.
    g_mask  = 4'h0;
    g_phase = 1'b0;
    step(1'b1, 16'h9ABC, g_mask, g_phase);
    run_to(FR - 1);
    run_to(2 * SD + 5);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    repeat (2) begin
      @(posedge clk);
      #1;
      chk_reset_outputs("async_hold");
    end
    rst_n = 1'b1;
    model_reset();
    run_to(FR - 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
